trace_monitor: RTL
==================

// Module: trace_monitor
// PURPOSE
//  Parametrised commit-trace and test-result monitor for the core. It snoops
//  CH_NUM register write-back channels and stores the commits in a circular
//  trace buffer that can be drained through a valid/ready port. It also
//  shadows the pass/fail register (gp) and flags pass, fail or timeout.
//  Sits beside the core on the write-back paths and replaces a fixed-length
//  bench run with a result-driven stop.
// PARAMETERS
//  CH_NUM     2     number of write-back channels (1..4)
//  DEPTH      64    trace entries; power of two, >= CH_NUM
//  TIMEOUT    4500  RUN cycles before a forced timeout; 0 disables the timeout
//  PASS_REG   3     architectural register holding the test result
//  OVERWRITE  1     1: drop the oldest entries when full; 0: drop new entries
//  FILTER_X0  1     1: ignore commits whose rd is 0
// PORTS
//  CLK        in   1          clock
//  RST        in   1          asynchronous, active-low reset
//  ENABLE     in   1          IDLE->RUN; while low in RUN, capture and counting pause
//  CLEAR      in   1          synchronous clear to the reset state (except the RAM)
//  WB_VALID   in   CH_NUM     per-channel commit valid
//  WB_PC      in   32*CH_NUM  commit pc, channel c at [32c+31:32c]
//  WB_RD      in   5*CH_NUM   destination register
//  WB_DATA    in   32*CH_NUM  write-back data
//  HALT_REQ   in   1          core reached ecall / end of test
//  RD_READY   in   1          consumer accepts the head entry
//  RD_VALID   out  1          trace buffer not empty
//  RD_CH      out  2          channel of the head entry
//  RD_PC      out  32         pc of the head entry
//  RD_RD      out  5          rd of the head entry
//  RD_DATA    out  32         data of the head entry
//  COUNT      out  clog2(DEPTH)+1  current occupancy
//  OVERFLOW   out  1          sticky: at least one entry was lost
//  STATE      out  2          0 IDLE, 1 RUN, 2 DONE
//  CYCLES     out  32         RUN cycles counted while ENABLE is high
//  PASS/FAIL/TIMED_OUT out 1  sticky result flags, valid in DONE
// BEHAVIOUR
//  Reset / CLEAR: all outputs 0, buffer empty, STATE=IDLE, gp shadow=0.
//   CLEAR takes priority over every other event in the same cycle.
//  FSM: IDLE->RUN when ENABLE=1; RUN->DONE on HALT_REQ, or when CYCLES reaches
//   TIMEOUT while no HALT_REQ is present. DONE is held until CLEAR.
//   HALT_REQ and the timeout in the same cycle: the halt wins.
//  Capture happens only in RUN with ENABLE=1. An entry is kept if it is valid
//   and not filtered out (FILTER_X0 with rd=0). Kept entries are written to
//   consecutive slots in ascending channel order, all in the same cycle.
//   Commits arriving in the HALT_REQ cycle are captured.
//  The entry is visible on RD_* one cycle after the write (registered RAM
//   output; RD_* is updated in the cycle after the write).
//  Pop: RD_VALID & RD_READY advances the head. Popping is allowed in any state.
//  Push+pop in the same cycle: free = DEPTH-COUNT+pop; COUNT += kept-pop.
//  Full: with k kept entries and free < k:
//   OVERWRITE=1: write all k, advance the head by k-free, set OVERFLOW.
//   OVERWRITE=0: write the lowest-channel free entries, drop the rest,
//    set OVERFLOW.
//  Pointers wrap modulo DEPTH. COUNT never exceeds DEPTH.
//  gp shadow: updated by any valid commit with rd=PASS_REG (the filter is not
//   applied). With several such commits in one cycle, the highest channel wins.
//   The shadow includes the commit of the current cycle when the halt is
//   evaluated.
//  On halt: PASS = (shadow==1); FAIL = !PASS. On timeout: TIMED_OUT=1, FAIL=1.
//  CYCLES saturates at 2^32-1 and freezes in DONE.
//  Reset mid-run: the buffer contents are discarded immediately; the
//   asynchronous assert clears all state.
// TESTING
//  1. Single commit ch0 pc=0x100 rd=5 data=0xA5 -> after 1 cycle RD_VALID=1,
//     RD_PC=0x100, RD_RD=5, RD_DATA=0xA5, COUNT=1.
//  2. Same cycle: ch0 rd=0, ch1 rd=7 (FILTER_X0=1) -> COUNT=1, RD_CH=1, RD_RD=7.
//  3. DEPTH=4, OVERWRITE=1: push 6 single commits with data 1..6 and no pop
//     -> COUNT=4, pop order 3,4,5,6, OVERFLOW=1. With OVERWRITE=0 -> 1,2,3,4.
//  4. Commit rd=3 data=1, then HALT_REQ -> STATE=2, PASS=1, FAIL=0.
//     With data=0x15 instead -> FAIL=1.
//  5. TIMEOUT=10, ENABLE held high, no halt -> STATE=2 exactly at CYCLES=10,
//     TIMED_OUT=1, FAIL=1.
//  6. COUNT=DEPTH with pop and 1 push in the same cycle -> COUNT unchanged,
//     OVERFLOW=0. Assert RST mid-run -> every output is 0 the same cycle.

Source files
------------

// File: rtl/trace_monitor.sv
// Commit-trace and test-result monitor. Snoops write-back channels into a circular trace
// buffer drained through a valid/ready port, and tracks pass/fail/timeout of the test.
module trace_monitor #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned TIMEOUT   = 4500,
  parameter int unsigned PASS_REG  = 3,
  parameter int unsigned OVERWRITE = 1,
  parameter int unsigned FILTER_X0 = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [CH_NUM-1:0]      wb_valid,
  input  logic [32*CH_NUM-1:0]   wb_pc,
  input  logic [5*CH_NUM-1:0]    wb_rd,
  input  logic [32*CH_NUM-1:0]   wb_data,
  input  logic                   halt_req,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [1:0]             rd_ch,
  output logic [31:0]            rd_pc,
  output logic [4:0]             rd_rd,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic [31:0]            cycles,
  output logic                   pass,
  output logic                   fail,
  output logic                   timed_out
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [31:0]     gp_q, gp_next;
  logic            pass_q, pass_d, fail_q, fail_d, timed_out_q, timed_out_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  entry_t          rd_q, rd_d;
  entry_t          mem_q [DEPTH];

  entry_t          wr_entry [CH_NUM];
  logic [PtrW-1:0] wr_slot [CH_NUM];
  logic [CntW-1:0] rank [CH_NUM];
  logic [CH_NUM-1:0] wr_en;
  logic [CntW-1:0] n_kept, n_wr, free, head_adv;
  logic            cap_en, pop, lost;

  assign cap_en = (state_q == StRun) && enable && !clear;
  assign pop    = (count_q != '0) && rd_ready;
  assign free   = CntW'(DEPTH) - count_q + CntW'(pop);

  // Buffer bookkeeping: kept entries take consecutive slots in channel order.
  always_comb begin
    n_kept = '0;
    wr_en  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      wr_entry[c] = '{ch: 2'(c), pc: wb_pc[32*c +: 32], rd: wb_rd[5*c +: 5],
                      data: wb_data[32*c +: 32]};
      rank[c]     = n_kept;
      wr_slot[c]  = tail_q + rank[c][PtrW-1:0];
      if (cap_en && wb_valid[c] && !(FILTER_X0 != 0 && wb_rd[5*c +: 5] == 5'd0)) begin
        wr_en[c] = (OVERWRITE != 0) || (n_kept < free);
        n_kept   = n_kept + CntW'(1);
      end
    end
    lost     = n_kept > free;
    n_wr     = (lost && OVERWRITE == 0) ? free : n_kept;
    head_adv = CntW'(pop);
    // Overwrite mode evicts the oldest entries to make room for every new one.
    if (lost && OVERWRITE != 0) head_adv = n_kept - free + CntW'(pop);
    tail_d     = tail_q + n_wr[PtrW-1:0];
    head_d     = head_q + head_adv[PtrW-1:0];
    count_d    = lost ? CntW'(DEPTH) : count_q + n_kept - CntW'(pop);
    overflow_d = overflow_q | lost;

    // Registered read port with forwarding of a same-cycle write to the new head slot.
    rd_d = mem_q[head_d];
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_en[c] && wr_slot[c] == head_d) rd_d = wr_entry[c];
    end
    if (count_d == '0) rd_d = '0;

    if (clear) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      rd_d       = '0;
    end
  end

  // Result register shadow: highest channel wins, filter not applied.
  always_comb begin
    gp_next = gp_q;
    for (int c = 0; c < CH_NUM; c++) begin
      if (wb_valid[c] && wb_rd[5*c +: 5] == 5'(PASS_REG)) gp_next = wb_data[32*c +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      StIdle: if (enable) state_d = StRun;
      StRun: begin
        if (enable && cycles_q != '1) cycles_d = cycles_q + 32'd1;
        if (halt_req) begin
          state_d = StDone;
          pass_d  = (gp_next == 32'd1);
          fail_d  = (gp_next != 32'd1);
        end else if (TIMEOUT != 0 && cycles_d >= 32'(TIMEOUT)) begin
          state_d     = StDone;
          timed_out_d = 1'b1;
          fail_d      = 1'b1;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d     = StIdle;
      cycles_d    = '0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timed_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cycles_q    <= '0;
      gp_q        <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timed_out_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      gp_q        <= clear ? 32'd0 : gp_next;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timed_out_q <= timed_out_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_en[c]) mem_q[wr_slot[c]] <= wr_entry[c];
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_ch     = rd_q.ch;
  assign rd_pc     = rd_q.pc;
  assign rd_rd     = rd_q.rd;
  assign rd_data   = rd_q.data;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign state     = state_q;
  assign cycles    = cycles_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timed_out = timed_out_q;

endmodule
